// File: rtl/game_result_ctrl.sv
// Round controller: start/play/over FSM with catch detection, cheese counting and a
// registered game-result code. Optional auto-restart from OVER: GAME_RESULT_AUTORESTART_EN.
module game_result_ctrl #(
    parameter int GAME_FRAMES  = 3600,
    parameter int CHEESE_WIN   = 5,
    parameter int CATCH_DIST   = 32,
    parameter int CATCH_FRAMES = 3,
    parameter int AUTO_FRAMES  = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        restart,
    input  logic        cheese_pulse,
    input  logic [11:0] tom_x,
    input  logic [11:0] tom_y,
    input  logic [11:0] jerry_x,
    input  logic [11:0] jerry_y,
    output logic [1:0]  over,
    output logic        playing,
    output logic [15:0] frames_left,
    output logic [7:0]  cheese_cnt
);

    generate
        if (GAME_FRAMES > 65535) begin : g_game_frames_too_wide
            $error("GAME_FRAMES must fit in the 16-bit frames_left counter");
        end
    endgenerate

    localparam logic [15:0] GAME_FRAMES_W  = 16'(GAME_FRAMES);
    localparam logic [7:0]  CHEESE_WIN_W   = 8'(CHEESE_WIN);
    localparam logic [12:0] CATCH_DIST_W   = 13'(CATCH_DIST);
    localparam logic [7:0]  CATCH_FRAMES_W = 8'(CATCH_FRAMES);

    localparam logic [1:0] OVER_NONE  = 2'b00;
    localparam logic [1:0] OVER_TOM   = 2'b10;
    localparam logic [1:0] OVER_JERRY = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  over_q, over_d;
    logic        playing_q, playing_d;
    logic [15:0] frames_left_q, frames_left_d;
    logic [7:0]  cheese_cnt_q, cheese_cnt_d;
    logic [7:0]  catch_cnt_q, catch_cnt_d;
    logic        restart_pend_q, restart_pend_d;
`ifdef GAME_RESULT_AUTORESTART_EN
    localparam logic [15:0] AUTO_FRAMES_W = 16'(AUTO_FRAMES);
    logic [15:0] auto_cnt_q, auto_cnt_d;
`endif

    // Larger-minus-smaller in 13 bits so the absolute distance never wraps.
    logic [12:0] dist_x, dist_y;
    logic        overlap;

    always_comb begin
        dist_x  = (tom_x >= jerry_x) ? ({1'b0, tom_x} - {1'b0, jerry_x})
                                     : ({1'b0, jerry_x} - {1'b0, tom_x});
        dist_y  = (tom_y >= jerry_y) ? ({1'b0, tom_y} - {1'b0, jerry_y})
                                     : ({1'b0, jerry_y} - {1'b0, tom_y});
        overlap = (dist_x < CATCH_DIST_W) && (dist_y < CATCH_DIST_W);
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        over_d         = over_q;
        playing_d      = playing_q;
        frames_left_d  = frames_left_q;
        cheese_cnt_d   = cheese_cnt_q;
        catch_cnt_d    = catch_cnt_q;
        restart_pend_d = restart_pend_q;
`ifdef GAME_RESULT_AUTORESTART_EN
        auto_cnt_d     = auto_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                over_d = OVER_NONE;
                if (start) begin
                    state_d        = ST_PLAY;
                    playing_d      = 1'b1;
                    frames_left_d  = GAME_FRAMES_W;
                    cheese_cnt_d   = 8'd0;
                    catch_cnt_d    = 8'd0;
                    restart_pend_d = 1'b0;
                end
            end

            ST_PLAY: begin
                if (cheese_pulse && (cheese_cnt_q != 8'hFF)) begin
                    cheese_cnt_d = cheese_cnt_q + 8'd1;
                end
                if (frame_tick) begin
                    if (!overlap) begin
                        catch_cnt_d = 8'd0;
                    end else if (catch_cnt_q != 8'hFF) begin
                        catch_cnt_d = catch_cnt_q + 8'd1;
                    end
                    if (frames_left_q != 16'd0) begin
                        frames_left_d = frames_left_q - 16'd1;
                    end

                    // Tom's catch outranks Jerry's cheese; timeout is the fallback.
                    if (catch_cnt_d >= CATCH_FRAMES_W) begin
                        over_d = OVER_TOM;
                    end else if (cheese_cnt_d >= CHEESE_WIN_W) begin
                        over_d = OVER_JERRY;
                    end else if (frames_left_d == 16'd0) begin
                        over_d = OVER_TOM;
                    end

                    if (over_d != OVER_NONE) begin
                        state_d        = ST_OVER;
                        playing_d      = 1'b0;
                        restart_pend_d = 1'b0;
`ifdef GAME_RESULT_AUTORESTART_EN
                        auto_cnt_d     = 16'd0;
`endif
                    end
                end
            end

            ST_OVER: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                // The visible clear waits for a frame_tick so it lands in blanking.
                if (frame_tick) begin
                    if (restart_pend_q) begin
                        state_d        = ST_IDLE;
                        over_d         = OVER_NONE;
                        restart_pend_d = 1'b0;
                    end
`ifdef GAME_RESULT_AUTORESTART_EN
                    else if (auto_cnt_q != AUTO_FRAMES_W) begin
                        auto_cnt_d = auto_cnt_q + 16'd1;
                        if (auto_cnt_d == AUTO_FRAMES_W) begin
                            restart_pend_d = 1'b1;
                        end
                    end
`endif
                end
            end

            default: begin
                state_d   = ST_IDLE;
                over_d    = OVER_NONE;
                playing_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            over_q         <= OVER_NONE;
            playing_q      <= 1'b0;
            frames_left_q  <= GAME_FRAMES_W;
            cheese_cnt_q   <= 8'd0;
            catch_cnt_q    <= 8'd0;
            restart_pend_q <= 1'b0;
`ifdef GAME_RESULT_AUTORESTART_EN
            auto_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            over_q         <= over_d;
            playing_q      <= playing_d;
            frames_left_q  <= frames_left_d;
            cheese_cnt_q   <= cheese_cnt_d;
            catch_cnt_q    <= catch_cnt_d;
            restart_pend_q <= restart_pend_d;
`ifdef GAME_RESULT_AUTORESTART_EN
            auto_cnt_q     <= auto_cnt_d;
`endif
        end
    end

    assign over        = over_q;
    assign playing     = playing_q;
    assign frames_left = frames_left_q;
    assign cheese_cnt  = cheese_cnt_q;

endmodule
